adder_sequencer: RTL
====================

# adder_sequencer

Upstream controller for the handshake adder. It accepts a serial stream of WIDTH-bit operands, pairs consecutive operands as A then B, and drives the adder's `en`/`inA`/`inB` inputs until `done` is returned. It captures the WIDTH+1-bit sum and presents it to the downstream consumer on a valid/ready port. A watchdog flags an adder that never asserts `done`.

## Interface
- `WIDTH`, default 3: operand width; must equal the adder's width parameter.
- `TIMEOUT`, default 15: maximum number of RUN cycles to wait for `add_done`. Range 1..255.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `in_data`  in  WIDTH: operand.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: operand accepted when `in_valid & in_ready` at a clock edge.
- `add_en`  out  1: drives adder `en`.
- `add_a`, `add_b`  out  WIDTH each: drive adder `inA`/`inB`.
- `add_sum`  in  WIDTH+1: adder `out`.
- `add_done`  in  1: adder `done`.
- `res_data`  out  WIDTH+1: captured sum.
- `res_valid`  out  1: `res_data` is valid.
- `res_ready`  in  1: consumer accepts when `res_valid & res_ready` at a clock edge.
- `err`  out  1: sticky timeout flag.

## Operation
- States: S_A, S_B, S_RUN, S_OUT. Encoding is free.
- **S_A**
  - `in_ready` = 1.
  - On handshake: `add_a` <= `in_data`, go to S_B.
- **S_B**
  - `in_ready` = 1.
  - On handshake: `add_b` <= `in_data`, clear the timeout counter, go to S_RUN.
- **S_RUN**
  - `add_en` = 1 for the whole state. `in_ready` = 0.
  - `add_a` and `add_b` are held stable.
  - `add_done` is sampled on every RUN cycle, including the first.
  - If `add_done` = 1: `res_data` <= `add_sum` (full WIDTH+1 bits, no truncation), go to S_OUT.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with no `done`: set `err`, leave `res_data` unchanged, go to S_A. No result is emitted for that pair.
- **S_OUT**
  - `res_valid` = 1, `add_en` = 0, `in_ready` = 0.
  - `res_data` is held until the handshake; then go to S_A.
  - `in_valid` asserted during S_OUT is not consumed.
- `err` is cleared only by reset. Operation continues normally after `err` is set.
- `add_en`, `in_ready` and `res_valid` are decoded from the registered state and are glitch-free. There is no combinational path from any input to any output.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State goes to S_A.
  - `add_a`, `add_b`, `res_data`, the counter and `err` go to 0.
  - `in_ready`, `add_en` and `res_valid` are forced to 0 while `rst_n` = 0.
  - `in_ready` = 1 in the first cycle after release.
- Reset during S_RUN or S_OUT aborts the pair: `add_en` drops in the cycle after the reset edge and no result is emitted.
- Minimum latency: the B handshake at edge k puts `add_en` high after edge k. If `add_done` = 1 at edge k+1, `res_valid` rises after edge k+1.
- Minimum throughput: 4 cycles per pair (A, B, RUN, OUT), with `res_ready` held at 1.
- With `add_done` tied low, `err` rises after exactly TIMEOUT RUN cycles and `in_ready` = 1 in the next cycle.
- `add_done` outside S_RUN is ignored.

## Test plan
- **Basic sum:** WIDTH = 3, operands 3 then 2, `res_ready` = 1. Require `res_data` = 5 with `res_valid` for one cycle, `add_en` high only during RUN, and `err` = 0.
- **Carry-out:** operands 7 then 4. Require `res_data` = 11 (4'b1011), with no truncation.
- **Backpressure:** 7 + 4 with `res_ready` = 0 for 5 cycles. Require `res_valid` and `res_data` = 11 held stable and `in_ready` = 0 throughout. Then pulse `res_ready`: the next cycle shows `in_ready` = 1.
- **Timeout:** TIMEOUT = 15, `add_done` held 0, operands 1 and 1. Require `add_en` high for exactly 15 cycles, then `err` = 1, no `res_valid`, and return to S_A. Next, 3 + 2 with a working adder gives 5 while `err` stays 1.
- **Reset mid-RUN:** assert `rst_n` = 0 for one cycle while `add_en` = 1. Require all outputs at 0 on the next cycle, `err` = 0, no result emitted, and a following pair 6 + 1 giving 7.
- **Streaming:** `in_valid` held 1 with operands 1, 2, 3, 4. Require results 3 then 7, in order, with operands 3 and 4 never accepted during S_RUN or S_OUT.

Source files
------------

// File: rtl/adder_sequencer.sv
// Pairs serial operands as A then B, runs the handshake adder until done, presents the sum on valid/ready.
// One RUN cycle minimum; watchdog raises sticky err after TIMEOUT RUN cycles without done.
module adder_sequencer #(
  parameter int WIDTH   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             add_en,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_sum,
  input  logic             add_done,
  output logic [WIDTH:0]   res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             err
);

  typedef enum logic [1:0] {S_A, S_B, S_RUN, S_OUT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic [WIDTH:0]   res_nxt;
  logic             err_nxt;
  // Registered copy of reset release; keeps handshake outputs low while reset is held
  // without a combinational path from rst_n.
  logic             alive;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_A;
      cnt      <= '0;
      add_a    <= '0;
      add_b    <= '0;
      res_data <= '0;
      err      <= 1'b0;
      alive    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      add_a    <= a_nxt;
      add_b    <= b_nxt;
      res_data <= res_nxt;
      err      <= err_nxt;
      alive    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = add_a;
    b_nxt     = add_b;
    res_nxt   = res_data;
    err_nxt   = err;
    case (state)
      S_A: begin
        if (in_valid && alive) begin
          a_nxt     = in_data;
          state_nxt = S_B;
        end
      end
      S_B: begin
        if (in_valid && alive) begin
          b_nxt     = in_data;
          cnt_nxt   = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (add_done) begin
          res_nxt   = add_sum;
          state_nxt = S_OUT;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_A;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      S_OUT: begin
        if (res_ready) state_nxt = S_A;
      end
      default: state_nxt = S_A;
    endcase
  end

  assign in_ready  = alive && (state == S_A || state == S_B);
  assign add_en    = alive && (state == S_RUN);
  assign res_valid = alive && (state == S_OUT);

endmodule
